// File: rtl/acc_apb_master_if.sv
// Command/response and APB bus bundle for the accelerator APB initiator.
// The master modport is the initiator's view; slave is the requester/APB target side.
interface acc_apb_master_if #(
   parameter int APB_ADDR_WIDTH = 13
);
   logic                      cmd_valid;
   logic                      cmd_ready;
   logic                      cmd_write;
   logic [APB_ADDR_WIDTH-1:0] cmd_addr;
   logic [31:0]               cmd_wdata;
   logic                      rsp_valid;
   logic [31:0]               rsp_rdata;
   logic                      rsp_err;
   logic                      rsp_timeout;
   logic                      busy;
   logic [APB_ADDR_WIDTH-1:0] PADDR;
   logic [31:0]               PWDATA;
   logic                      PWRITE;
   logic                      PSEL;
   logic                      PENABLE;
   logic [31:0]               PRDATA;
   logic                      PREADY;
   logic                      PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
             PADDR, PWDATA, PWRITE, PSEL, PENABLE
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
             PADDR, PWDATA, PWRITE, PSEL, PENABLE
   );
endinterface

// File: rtl/acc_apb_master.sv
// APB initiator: one command at a time, SETUP then ACCESS, honours PREADY
// wait states and aborts a stuck ACCESS after TIMEOUT_CYCLES (0 = never).
//
// state  | meaning
// IDLE   | ready for a command, PSEL low
// SETUP  | PSEL high, PENABLE low, exactly one cycle
// ACCESS | PSEL and PENABLE high, waiting for PREADY or timeout
module acc_apb_master #(
   parameter int APB_ADDR_WIDTH = 13,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_WIDTH      = 9
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   acc_apb_master_if.master       bus
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   localparam logic [CNT_WIDTH-1:0] TO_LIM = CNT_WIDTH'(TIMEOUT_CYCLES);

   state_t                    state, state_n;
   logic                      psel, psel_n, penable, penable_n, pwrite, pwrite_n;
   logic [APB_ADDR_WIDTH-1:0] paddr, paddr_n;
   logic [31:0]               pwdata, pwdata_n, rsp_rdata, rsp_rdata_n;
   logic                      rsp_valid, rsp_valid_n, rsp_err, rsp_err_n;
   logic                      rsp_to, rsp_to_n, busy;
   logic [CNT_WIDTH-1:0]      wait_cnt, cnt_n, cnt_inc;

   // saturating increment so a disabled timeout can never wrap the counter
   assign cnt_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + CNT_WIDTH'(1);

   always_comb begin
      state_n     = state;
      psel_n      = psel;
      penable_n   = penable;
      pwrite_n    = pwrite;
      paddr_n     = paddr;
      pwdata_n    = pwdata;
      rsp_valid_n = 1'b0;
      rsp_rdata_n = rsp_rdata;
      rsp_err_n   = rsp_err;
      rsp_to_n    = rsp_to;
      cnt_n       = wait_cnt;
      case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               paddr_n   = bus.cmd_addr;
               pwrite_n  = bus.cmd_write;
               pwdata_n  = bus.cmd_write ? bus.cmd_wdata : 32'h0;
               psel_n    = 1'b1;
               penable_n = 1'b0;
               cnt_n     = '0;
               state_n   = SETUP;
            end
         end
         SETUP: begin
            penable_n = 1'b1;
            state_n   = ACCESS;
         end
         ACCESS: begin
            // completion takes priority over a timeout on the same edge
            if (bus.PREADY) begin
               psel_n      = 1'b0;
               penable_n   = 1'b0;
               rsp_valid_n = 1'b1;
               rsp_rdata_n = pwrite ? 32'h0 : bus.PRDATA;
               rsp_err_n   = bus.PSLVERR;
               rsp_to_n    = 1'b0;
               cnt_n       = '0;
               state_n     = IDLE;
            end else begin
               cnt_n = cnt_inc;
               if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIM)) begin
                  psel_n      = 1'b0;
                  penable_n   = 1'b0;
                  rsp_valid_n = 1'b1;
                  rsp_rdata_n = 32'h0;
                  rsp_err_n   = 1'b1;
                  rsp_to_n    = 1'b1;
                  cnt_n       = '0;
                  state_n     = IDLE;
               end
            end
         end
         default: begin
            psel_n    = 1'b0;
            penable_n = 1'b0;
            state_n   = IDLE;
         end
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= IDLE;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         rsp_to    <= 1'b0;
         busy      <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         state     <= state_n;
         psel      <= psel_n;
         penable   <= penable_n;
         pwrite    <= pwrite_n;
         paddr     <= paddr_n;
         pwdata    <= pwdata_n;
         rsp_valid <= rsp_valid_n;
         rsp_rdata <= rsp_rdata_n;
         rsp_err   <= rsp_err_n;
         rsp_to    <= rsp_to_n;
         busy      <= (state_n != IDLE);
         wait_cnt  <= cnt_n;
      end
   end

   assign bus.cmd_ready   = (state == IDLE);
   assign bus.PSEL        = psel;
   assign bus.PENABLE     = penable;
   assign bus.PWRITE      = pwrite;
   assign bus.PADDR       = paddr;
   assign bus.PWDATA      = pwdata;
   assign bus.rsp_valid   = rsp_valid;
   assign bus.rsp_rdata   = rsp_rdata;
   assign bus.rsp_err     = rsp_err;
   assign bus.rsp_timeout = rsp_to;
   assign bus.busy        = busy;

endmodule

// File: tb/tb_acc_apb_master.sv
// Directed bench for acc_apb_master: a table of single transfers with a
// hand-computed response, plus reset-mid-transfer and back-to-back sequences.
module tb_acc_apb_master;

   localparam int AW = 13;
   localparam int TO = 8;

   logic HCLK = 1'b0;
   logic HRESETn = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   acc_apb_master_if #(.APB_ADDR_WIDTH(AW)) bus ();

   acc_apb_master #(
      .APB_ADDR_WIDTH(AW),
      .TIMEOUT_CYCLES(TO),
      .CNT_WIDTH(9)
   ) dut (
      .HCLK(HCLK),
      .HRESETn(HRESETn),
      .bus(bus.master)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic          write;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
      int            waits;     // PREADY low this many ACCESS cycles; >=TO means never ready
      logic [31:0]   prdata;
      logic          pslverr;
      logic [31:0]   exp_rdata;
      logic          exp_err;
      logic          exp_to;
      int            exp_access; // cycles PENABLE is high
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic do_xfer(input vec_t v, input int idx);
      logic [31:0] exp_pwdata;
      bit          done;
      int          k;
      exp_pwdata = v.write ? v.wdata : 32'h0;
      chk($sformatf("v%0d cmd_ready idle", idx), 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = v.write;
      bus.cmd_addr  = v.addr;
      bus.cmd_wdata = v.wdata;
      bus.PREADY    = 1'b0;
      tick();
      bus.cmd_valid = 1'b0;
      bus.cmd_wdata = 32'hFFFF_FFFF;
      chk($sformatf("v%0d setup psel", idx), 32'(bus.PSEL), 32'd1);
      chk($sformatf("v%0d setup penable", idx), 32'(bus.PENABLE), 32'd0);
      chk($sformatf("v%0d setup busy", idx), 32'(bus.busy), 32'd1);
      chk($sformatf("v%0d setup cmd_ready", idx), 32'(bus.cmd_ready), 32'd0);
      chk($sformatf("v%0d paddr", idx), 32'(bus.PADDR), 32'(v.addr));
      chk($sformatf("v%0d pwrite", idx), 32'(bus.PWRITE), 32'(v.write));
      chk($sformatf("v%0d pwdata", idx), bus.PWDATA, exp_pwdata);
      tick();
      done = 1'b0;
      k = 0;
      while (!done && k < 3 * TO) begin
         chk($sformatf("v%0d access psel c%0d", idx, k), 32'(bus.PSEL), 32'd1);
         chk($sformatf("v%0d access penable c%0d", idx, k), 32'(bus.PENABLE), 32'd1);
         chk($sformatf("v%0d access paddr c%0d", idx, k), 32'(bus.PADDR), 32'(v.addr));
         chk($sformatf("v%0d access pwdata c%0d", idx, k), bus.PWDATA, exp_pwdata);
         chk($sformatf("v%0d access rsp_valid c%0d", idx, k), 32'(bus.rsp_valid), 32'd0);
         if (k == v.waits) begin
            bus.PREADY  = 1'b1;
            bus.PRDATA  = v.prdata;
            bus.PSLVERR = v.pslverr;
         end else begin
            bus.PREADY  = 1'b0;
            bus.PRDATA  = 32'h5A5A_0000 + 32'(k);
            bus.PSLVERR = 1'b1;
         end
         done = (k == v.waits) || (k + 1 == TO);
         k++;
         tick();
      end
      bus.PREADY  = 1'b0;
      bus.PSLVERR = 1'b0;
      bus.PRDATA  = 32'h0;
      chk($sformatf("v%0d access cycles", idx), 32'(k), 32'(v.exp_access));
      chk($sformatf("v%0d done psel", idx), 32'(bus.PSEL), 32'd0);
      chk($sformatf("v%0d done penable", idx), 32'(bus.PENABLE), 32'd0);
      chk($sformatf("v%0d rsp_valid", idx), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("v%0d rsp_rdata", idx), bus.rsp_rdata, v.exp_rdata);
      chk($sformatf("v%0d rsp_err", idx), 32'(bus.rsp_err), 32'(v.exp_err));
      chk($sformatf("v%0d rsp_timeout", idx), 32'(bus.rsp_timeout), 32'(v.exp_to));
      chk($sformatf("v%0d done busy", idx), 32'(bus.busy), 32'd0);
      chk($sformatf("v%0d done cmd_ready", idx), 32'(bus.cmd_ready), 32'd1);
      tick();
      chk($sformatf("v%0d rsp_valid drop", idx), 32'(bus.rsp_valid), 32'd0);
      chk($sformatf("v%0d rsp_rdata hold", idx), bus.rsp_rdata, v.exp_rdata);
      chk($sformatf("v%0d rsp_err hold", idx), 32'(bus.rsp_err), 32'(v.exp_err));
      chk($sformatf("v%0d paddr hold", idx), 32'(bus.PADDR), 32'(v.addr));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n_acc, n_xfer, n_rsp;
      int          acc_cyc[3];
      bit          prev_acc, prev_xfer;
      logic [AW-1:0] exp_a;
      logic [31:0]   exp_d;

      //        wr    addr      wdata         waits prdata        slverr rdata         err  to  access
      vecs[0] = '{1'b1, 13'h1FFF, 32'h0000_0001, 0,   32'h1111_1111, 1'b0, 32'h0,        1'b0, 1'b0, 1};
      vecs[1] = '{1'b0, 13'h0004, 32'h0,         3,   32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 4};
      vecs[2] = '{1'b1, 13'h0002, 32'h1234_5678, 0,   32'h2222_2222, 1'b1, 32'h0,        1'b1, 1'b0, 1};
      vecs[3] = '{1'b0, 13'h0100, 32'h0,         100, 32'h3333_3333, 1'b0, 32'h0,        1'b1, 1'b1, 8};
      vecs[4] = '{1'b0, 13'h00AA, 32'h0,         7,   32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 8};
      vecs[5] = '{1'b0, 13'h1000, 32'h0,         0,   32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b0, 1};
      vecs[6] = '{1'b1, 13'h0055, 32'h7777_7777, 100, 32'h4444_4444, 1'b0, 32'h0,        1'b1, 1'b1, 8};

      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = 32'h0;
      bus.PRDATA    = 32'h0;
      bus.PREADY    = 1'b0;
      bus.PSLVERR   = 1'b0;
      #12 HRESETn = 1'b1;
      tick();
      chk("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("reset psel", 32'(bus.PSEL), 32'd0);
      chk("reset penable", 32'(bus.PENABLE), 32'd0);
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("reset rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("reset paddr", 32'(bus.PADDR), 32'd0);

      for (int i = 0; i < 7; i++) do_xfer(vecs[i], i);

      // reset in the middle of an ACCESS wait
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 13'h0123;
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      tick();
      chk("rst pre penable", 32'(bus.PENABLE), 32'd1);
      #2 HRESETn = 1'b0;
      #1;
      chk("rst async psel", 32'(bus.PSEL), 32'd0);
      chk("rst async penable", 32'(bus.PENABLE), 32'd0);
      chk("rst async busy", 32'(bus.busy), 32'd0);
      chk("rst async cmd_ready", 32'(bus.cmd_ready), 32'd1);
      @(posedge HCLK);
      #3 HRESETn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("rst no rsp_valid c%0d", c), 32'(bus.rsp_valid), 32'd0);
         chk($sformatf("rst idle psel c%0d", c), 32'(bus.PSEL), 32'd0);
      end
      do_xfer(vecs[1], 11);

      // three back-to-back writes with cmd_valid held and PREADY always high
      n_acc = 0; n_xfer = 0; n_rsp = 0;
      acc_cyc = '{0, 0, 0};
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 13'h0001;
      bus.cmd_wdata = 32'h0000_00A1;
      bus.PREADY    = 1'b1;
      exp_a = bus.cmd_addr;
      exp_d = bus.cmd_wdata;
      prev_acc  = bus.cmd_valid && bus.cmd_ready;
      prev_xfer = 1'b0;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         tick();
         if (prev_acc) begin
            if (n_acc < 3) acc_cyc[n_acc] = cyc;
            n_acc++;
            chk($sformatf("b2b paddr a%0d", n_acc), 32'(bus.PADDR), 32'(exp_a));
            chk($sformatf("b2b pwdata a%0d", n_acc), bus.PWDATA, exp_d);
            if (n_acc == 1) bus.cmd_wdata = 32'h0000_00A2;
            if (n_acc == 2) begin
               bus.cmd_addr  = 13'h1FFF;
               bus.cmd_wdata = 32'h0;
            end
            if (n_acc >= 3) bus.cmd_valid = 1'b0;
            exp_a = bus.cmd_addr;
            exp_d = bus.cmd_wdata;
         end
         if (prev_xfer) n_xfer++;
         if (bus.rsp_valid) n_rsp++;
         prev_acc  = bus.cmd_valid && bus.cmd_ready;
         prev_xfer = bus.PSEL && bus.PENABLE && bus.PREADY;
      end
      bus.PREADY = 1'b0;
      chk("b2b accepts", 32'(n_acc), 32'd3);
      chk("b2b apb transfers", 32'(n_xfer), 32'd3);
      chk("b2b rsp pulses", 32'(n_rsp), 32'd3);
      chk("b2b spacing 1-2", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      chk("b2b spacing 2-3", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
      chk("b2b last rdata", bus.rsp_rdata, 32'h0);
      chk("b2b last err", 32'(bus.rsp_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/acc_apb_master.md
Name: acc_apb_master

Overview:
APB initiator that drives the accelerator's APB slave port from a simple command/response interface. It is used by the test harness and by the on-chip sequencer. Typical traffic: load A words, load X words, write the enable/end register, and read results back from the accelerator RAM. One transfer is in flight at a time. Every transfer gets SETUP and ACCESS phases, PREADY wait states are honoured, and a wait-state timeout is enforced.

Parameters:
APB_ADDR_WIDTH, 13, PADDR width (8 KB slave window).
TIMEOUT_CYCLES, 256, maximum ACCESS cycles with PREADY=0 before abort; 0 disables the timeout.
CNT_WIDTH, 9, width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
HCLK  in  1  single clock.
HRESETn  in  1  asynchronous active-low reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at a rising edge.
cmd_write  in  1  1=write, 0=read.
cmd_addr  in  APB_ADDR_WIDTH  target address.
cmd_wdata  in  32  write data; ignored for reads.
rsp_valid  out  1  one-cycle completion pulse.
rsp_rdata  out  32  read data; 0 for writes and for timeouts.
rsp_err  out  1  PSLVERR seen, or timeout.
rsp_timeout  out  1  transfer aborted by timeout.
busy  out  1  state != IDLE.
PADDR  out  APB_ADDR_WIDTH  APB address.
PWDATA  out  32  APB write data.
PWRITE  out  1  APB direction.
PSEL  out  1  APB select.
PENABLE  out  1  APB enable.
PRDATA  in  32  APB read data.
PREADY  in  1  APB ready.
PSLVERR  in  1  APB error.

Behaviour:
- Reset (async assert, sync release): state=IDLE. All APB outputs, rsp_*, busy and the wait counter are 0; cmd_ready=1. Reset mid-transfer drops PSEL/PENABLE immediately and produces no rsp_valid.
- All outputs are registered except cmd_ready, which is decoded from state: cmd_ready=(state==IDLE).
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: on accept, latch PADDR=cmd_addr, PWRITE=cmd_write, PWDATA=(cmd_write?cmd_wdata:0); set PSEL=1, PENABLE=0; go to SETUP.
  - SETUP: lasts exactly 1 cycle; set PENABLE=1; go to ACCESS. PADDR/PWRITE/PWDATA are stable from SETUP through the end of ACCESS.
  - ACCESS, PREADY=1 at an edge: complete. Clear PSEL/PENABLE. rsp_valid=1 for the next cycle. rsp_rdata=PWRITE?0:PRDATA. rsp_err=PSLVERR, rsp_timeout=0. Clear the wait counter. Go to IDLE.
  - ACCESS, PREADY=0: increment the wait counter. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, abort: clear PSEL/PENABLE, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to IDLE.
  - If PREADY=1 on the same edge the counter would hit the limit, completion wins.
- Latency: accept at edge N. PSEL is high during N..N+1. PENABLE is high from N+1 until completion. With zero wait states, rsp_valid is high during cycle N+2..N+3. Maximum throughput is 1 transfer per 3 cycles; a new command can be accepted in the same cycle rsp_valid is high.
- rsp_valid is a pulse with no backpressure. rsp_* data holds its value until the next completion; only rsp_valid drops.
- PSLVERR and PRDATA are sampled only at the completing edge. PADDR/PWDATA keep their last values in IDLE, and PSEL=0 there.
- cmd_valid while busy is ignored; the requester must hold it until accepted. There are no duplicate or dropped accepts.
- The wait counter saturates; it never wraps.

Test Plan:
1. Write 0x00000001 to 0x1FFF with PREADY=1 → PSEL high 2 cycles, PENABLE high 1 cycle, PWRITE=1, PWDATA=0x1. rsp_valid on the 3rd cycle after accept, rsp_err=0, rsp_rdata=0.
2. Read 0x004; PREADY low for 3 ACCESS cycles, then high with PRDATA=0xDEADBEEF → PENABLE high 4 cycles, PADDR stable throughout. rsp_rdata=0xDEADBEEF, rsp_err=0.
3. Write 0x002 with PSLVERR=1 at completion → rsp_err=1, rsp_timeout=0, FSM back in IDLE, cmd_ready=1.
4. TIMEOUT_CYCLES=8, PREADY stuck 0 → after 8 ACCESS cycles PSEL/PENABLE=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with PREADY=1 on the 8th edge → normal completion, rsp_timeout=0.
5. Assert HRESETn=0 mid-ACCESS → PSEL/PENABLE/busy=0 without waiting for a clock edge; no rsp_valid after release; the next command completes normally.
6. Hold cmd_valid for 3 back-to-back writes (0x001 ×2, then 0x1FFF=0) with PREADY=1 → exactly 3 APB transfers, accepts spaced 3 cycles apart, 3 rsp_valid pulses, no commands while busy.
